// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types, constants and helpers for the display scan controller
package disp_pkg;
  localparam int NIBBLE_W         = 4;
  localparam int MAX_DIGITS       = 8;
  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_REFRESH_DIV  = 2500;
  localparam int DEF_BLANK_CYCLES = 16;

  typedef enum logic [1:0] {OFF, BLANK, SHOW} scan_state_e;

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/disp_slot_timer.sv
// rtl/disp_slot_timer.sv - per-digit slot counter and digit index with slot/frame strobes
module disp_slot_timer import disp_pkg::*; #(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  localparam int CNT_W = $clog2(REFRESH_DIV),
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [CNT_W-1:0] slot_cnt,
  output logic [IDX_W-1:0] digit_idx,
  output logic             slot_end,
  output logic             frame_wrap
);
  assign slot_end   = (slot_cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_wrap = slot_end && (digit_idx == IDX_W'(NUM_DIGITS - 1));

  // digit_idx wraps at NUM_DIGITS-1 explicitly so non-power-of-two digit counts work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (!run) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      slot_cnt  <= '0;
      digit_idx <= frame_wrap ? '0 : digit_idx + IDX_W'(1);
    end else begin
      slot_cnt  <= slot_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - multiplexed seven-segment scan controller with tear-free frame commits
module disp_scan_ctrl import disp_pkg::*; #(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scan_en,
  input  logic                         lz_suppress,
  input  logic                         load_valid,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data,
  output logic                         load_ready,
  output logic [NIBBLE_W-1:0]          digit_value,
  output logic                         seg_blank,
  output logic [NUM_DIGITS-1:0]        digit_sel,
  output logic                         frame_start
);
  localparam int DATA_W = NIBBLE_W * NUM_DIGITS;
  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  scan_state_e         state_q, state_d;
  logic [CNT_W-1:0]    slot_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic                slot_end, frame_wrap;
  logic [DATA_W-1:0]   display_reg, pending;
  logic                pending_valid, pending_valid_d, lz_q;
  logic                boundary, transfer, show;
  logic [NIBBLE_W-1:0] nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] supp;
  logic                upper_zero;

  disp_slot_timer #(.REFRESH_DIV(REFRESH_DIV), .NUM_DIGITS(NUM_DIGITS)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (scan_en && (state_q != OFF)),
    .slot_cnt   (slot_cnt),
    .digit_idx  (digit_idx),
    .slot_end   (slot_end),
    .frame_wrap (frame_wrap)
  );

  always_comb begin
    state_d = state_q;
    if (!scan_en) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF:     state_d = BLANK;
        BLANK:   if (slot_cnt == CNT_W'(BLANK_CYCLES - 1)) state_d = SHOW;
        SHOW:    if (slot_end) state_d = BLANK;
        default: state_d = OFF;
      endcase
    end
  end

  // A load arriving on a boundary cycle lands in pending only; it commits next frame
  assign boundary        = scan_en && ((state_q == OFF) || frame_wrap);
  assign transfer        = load_valid && !pending_valid;
  assign pending_valid_d = transfer || (pending_valid && !boundary);
  assign show            = scan_en && (state_q == SHOW);

  always_comb begin
    supp       = '0;
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) nib[k] = display_reg[k*NIBBLE_W +: NIBBLE_W];
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      upper_zero = upper_zero && (nib[k] == '0);
      supp[k]    = lz_q && upper_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= OFF;
      display_reg   <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      lz_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_valid <= pending_valid_d;
      if (transfer) pending <= load_data;
      if (boundary) begin
        lz_q <= lz_suppress;
        if (pending_valid) display_reg <= pending;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_value <= '0;
      seg_blank   <= 1'b1;
      digit_sel   <= '0;
      frame_start <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      load_ready  <= !pending_valid_d;
      frame_start <= scan_en && (state_q == BLANK) && (slot_cnt == '0) && (digit_idx == '0);
      if (show) begin
        digit_sel   <= NUM_DIGITS'(onehot(3'(digit_idx)));
        digit_value <= nib[digit_idx];
        seg_blank   <= supp[digit_idx];
      end else begin
        digit_sel   <= '0;
        seg_blank   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - randomized bench for disp_scan_ctrl against a position-based model
module tb_disp_scan_ctrl;
  localparam int N  = 4;
  localparam int R  = 8;
  localparam int B  = 2;
  localparam int FR = N * R;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        lz_suppress = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_ready, seg_blank, frame_start;
  logic [3:0]  digit_value;
  logic [3:0]  digit_sel;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: one position counter over the whole frame, in internal (pre-output) time
  bit          m_run;
  int          m_pos;
  logic [15:0] m_disp, m_pend;
  bit          m_pend_v, m_lz;
  logic [3:0]  e_sel, e_val;
  bit          e_blank, e_fs, e_ready;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .lz_suppress (lz_suppress),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .digit_value (digit_value),
    .seg_blank   (seg_blank),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_disp = '0; m_pend = '0; m_pend_v = 0; m_lz = 0;
    e_sel = '0; e_val = '0; e_blank = 1; e_fs = 0; e_ready = 1;
  endtask

  task automatic model_edge();
    int d;
    bit bnd, xfer;
    d = m_pos / R;
    if (scan_en && m_run && (m_pos % R) >= B) begin
      e_sel   = 4'(1 << d);
      e_val   = m_disp[4*d +: 4];
      e_blank = m_lz && (d > 0) && ((m_disp >> (4*d)) == 16'h0);
    end else begin
      e_sel   = '0;
      e_blank = 1;
    end
    e_fs = scan_en && m_run && (m_pos == 0);
    bnd  = scan_en && (!m_run || m_pos == FR - 1);
    xfer = load_valid && !m_pend_v;
    if (!scan_en) begin
      m_run = 0; m_pos = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FR;
    end
    if (bnd) begin
      m_lz = lz_suppress;
      if (m_pend_v) begin m_disp = m_pend; m_pend_v = 0; end
    end
    if (xfer) begin m_pend = load_data; m_pend_v = 1; end
    e_ready = !m_pend_v;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("digit_sel",   32'(digit_sel),   32'(e_sel));
    check("seg_blank",   32'(seg_blank),   32'(e_blank));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("load_ready",  32'(load_ready),  32'(e_ready));
    if (e_sel != '0) check("digit_value", 32'(digit_value), 32'(e_val));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit_sel"},   32'(digit_sel),   32'h0);
    check({tag, "_seg_blank"},   32'(seg_blank),   32'h1);
    check({tag, "_frame_start"}, 32'(frame_start), 32'h0);
    check({tag, "_load_ready"},  32'(load_ready),  32'h1);
    check({tag, "_digit_value"}, 32'(digit_value), 32'h0);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic offer(input logic [15:0] d);
    bit took;
    took = 0;
    load_valid = 1'b1;
    load_data  = d;
    for (int i = 0; i < 4 * FR && !took; i++) begin
      took = !m_pend_v;
      step();
    end
    load_valid = 1'b0;
    check("offer_accepted", 32'(took), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    scan_en = 1'b1;
    offer(16'h1234);
    repeat (3 * FR) step();

    offer(16'hAAAA);
    offer(16'h5555);
    repeat (2 * FR) step();

    for (int i = 0; i < 2 * FR && !(m_run && m_pos == FR - 1); i++) step();
    load_valid = 1'b1;
    load_data  = 16'h9876;
    step();
    load_valid = 1'b0;
    repeat (2 * FR + 4) step();

    lz_suppress = 1'b1;
    offer(16'h0050);
    repeat (2 * FR + 2) step();
    offer(16'h0000);
    repeat (2 * FR) step();
    lz_suppress = 1'b0;

    for (int i = 0; i < 2 * FR && !(m_run && m_pos == 2 * R + 4); i++) step();
    scan_en = 1'b0;
    repeat (5) step();
    scan_en = 1'b1;
    repeat (2 * FR) step();

    scan_en = 1'b0;
    offer(16'hBEEF);
    async_reset();
    scan_en = 1'b1;
    repeat (2 * FR) step();

    for (int i = 0; i < 3000; i++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       load_data = 16'($urandom);
        1:       load_data = 16'($urandom) & 16'h00FF;
        2:       load_data = 16'($urandom) & 16'h000F;
        default: load_data = 16'h0000;
      endcase
      if ($urandom_range(0, 99) == 0) lz_suppress = ~lz_suppress;
      if ($urandom_range(0, 199) == 0) scan_en = 1'b0;
      else if ($urandom_range(0, 7) == 0) scan_en = 1'b1;
      if ($urandom_range(0, 999) == 0) async_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
